// File: rtl/lane_pkg.sv
// Shared lane definitions: byte width, comma symbol and the scheduler state encoding.
// The serializer and deserializer use this package too.
package lane_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] COM_SYM = 8'hBC;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        BUSY = 2'd2
    } lane_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after ptr,
// wrapping modulo N, returned both one-hot and as an index.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/lane_tx_scheduler.sv
// Transmit byte scheduler for one lane: keeps packets atomic between requesters,
// emits COM as filler, as post-reset sync and as a periodic forced sync.
module lane_tx_scheduler
    import lane_pkg::*;
#(
    parameter int                NUM_REQ     = 4,
    parameter logic [BYTE_W-1:0] COM_SYM     = lane_pkg::COM_SYM,
    parameter int                SYNC_LEN    = 4,
    parameter int                SYNC_PERIOD = 16,
    parameter int                STALL_MAX   = 8
) (
    input  logic                      clock4,
    input  logic                      reset_L,
    input  logic [NUM_REQ-1:0]        valid_in,
    input  logic [NUM_REQ-1:0]        last_in,
    input  logic [BYTE_W*NUM_REQ-1:0] data_in,
    output logic [NUM_REQ-1:0]        ack_out,
    output logic [BYTE_W-1:0]         data_out,
    output logic                      valid_out,
    output logic                      err_out
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int SYNC_W  = $clog2(SYNC_LEN + 1);
    localparam int STALL_W = $clog2(STALL_MAX + 1);
    localparam int RUN_W   = $clog2(SYNC_PERIOD + 1);

    lane_state_t        state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [SYNC_W-1:0]  sync_q, sync_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [RUN_W-1:0]   run_q;
    logic               bad_q;

    logic [NUM_REQ-1:0] ack;
    logic [IDX_W-1:0]   sel;
    logic [BYTE_W-1:0]  sel_byte;
    logic               abort;
    logic               forced;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_found;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (valid_in),
        .ptr   (rr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .found (arb_found)
    );

    // A full run of data bytes freezes the whole scheduler for one COM cycle.
    assign forced   = (run_q == RUN_W'(SYNC_PERIOD));
    assign sel_byte = data_in[BYTE_W*sel +: BYTE_W];
    assign ack_out  = ack;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        sync_d  = sync_q;
        stall_d = stall_q;
        ack     = '0;
        sel     = owner_q;
        abort   = 1'b0;
        if (reset_L && !forced) begin
            case (state_q)
                SYNC: begin
                    if (sync_q == SYNC_W'(SYNC_LEN - 1)) begin
                        state_d = IDLE;
                    end else begin
                        sync_d = sync_q + SYNC_W'(1);
                    end
                end
                IDLE: begin
                    if (arb_found) begin
                        ack = arb_grant;
                        sel = arb_idx;
                        if (last_in[arb_idx]) begin
                            rr_d = next_idx(arb_idx);
                        end else begin
                            state_d = BUSY;
                            owner_d = arb_idx;
                            stall_d = '0;
                        end
                    end
                end
                BUSY: begin
                    // A returning owner byte wins over an abort in the same cycle.
                    if (valid_in[owner_q]) begin
                        ack[owner_q] = 1'b1;
                        stall_d      = '0;
                        if (last_in[owner_q]) begin
                            state_d = IDLE;
                            rr_d    = next_idx(owner_q);
                        end
                    end else if (stall_q == STALL_W'(STALL_MAX - 1)) begin
                        abort   = 1'b1;
                        stall_d = '0;
                        state_d = IDLE;
                        rr_d    = next_idx(owner_q);
                    end else begin
                        stall_d = stall_q + STALL_W'(1);
                    end
                end
                default: state_d = SYNC;
            endcase
        end
    end

    always_ff @(posedge clock4) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_L) begin
            state_q   <= SYNC;
            rr_q      <= '0;
            owner_q   <= '0;
            sync_q    <= '0;
            stall_q   <= '0;
            run_q     <= '0;
            bad_q     <= 1'b0;
            data_out  <= COM_SYM;
            valid_out <= 1'b0;
            err_out   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            sync_q  <= sync_d;
            stall_q <= stall_d;
            if (|ack) begin
                data_out  <= sel_byte;
                valid_out <= 1'b1;
                run_q     <= run_q + RUN_W'(1);
            end else begin
                data_out  <= COM_SYM;
                valid_out <= 1'b0;
                run_q     <= '0;
            end
            // An illegal 0xBC data byte is flagged the cycle after it leaves.
            bad_q   <= (|ack) && (sel_byte == COM_SYM);
            err_out <= abort || bad_q;
        end
    end

endmodule

// File: tb/tb_lane_tx_scheduler.sv
// Self-checking bench for lane_tx_scheduler: directed scenarios plus random traffic,
// all checked against a packet-level reference model of the lane rules.
module tb_lane_tx_scheduler;

    localparam int N           = 4;
    localparam logic [7:0] COM = 8'hBC;
    localparam int SYNC_LEN    = 4;
    localparam int SYNC_PERIOD = 16;
    localparam int STALL_MAX   = 8;

    logic           clock4 = 1'b0;
    logic           reset_L;
    logic [N-1:0]   valid_in;
    logic [N-1:0]   last_in;
    logic [8*N-1:0] data_in;
    logic [N-1:0]   ack_out;
    logic [7:0]     data_out;
    logic           valid_out;
    logic           err_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Requester scripts: bit 9 = one idle cycle, bit 8 = last, [7:0] = byte.
    logic [9:0] src_q [N][$];

    logic [N-1:0] log_ack   [$];
    logic [7:0]   log_data  [$];
    logic         log_valid [$];
    logic         log_err   [$];

    // Reference model: open packet owner (-1 = none), next round-robin start, data run length.
    int   m_sync_left, m_open, m_next, m_run, m_stall;
    logic m_bad;

    lane_tx_scheduler #(
        .NUM_REQ(N), .COM_SYM(COM), .SYNC_LEN(SYNC_LEN),
        .SYNC_PERIOD(SYNC_PERIOD), .STALL_MAX(STALL_MAX)
    ) dut (
        .clock4(clock4), .reset_L(reset_L), .valid_in(valid_in), .last_in(last_in),
        .data_in(data_in), .ack_out(ack_out), .data_out(data_out),
        .valid_out(valid_out), .err_out(err_out)
    );

    always #5 clock4 = ~clock4;

    task automatic push_byte(input int r, input logic [7:0] d, input logic last);
        src_q[r].push_back({1'b0, last, d});
    endtask

    task automatic push_gaps(input int r, input int n);
        for (int i = 0; i < n; i++) src_q[r].push_back(10'h200);
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_logs();
        log_ack.delete(); log_data.delete(); log_valid.delete(); log_err.delete();
    endtask

    // One clock cycle: drive requesters, predict and compare ack, then compare registered outputs.
    task automatic tick();
        logic [N-1:0] v, l, exp_ack, act_ack;
        logic [7:0]   d [N];
        logic [7:0]   exp_data;
        logic         exp_valid, exp_err, abort;
        int           w;
        v = '0; l = '0; exp_ack = '0; abort = 1'b0;
        for (int i = 0; i < N; i++) begin
            d[i] = 8'h00;
            if (src_q[i].size() > 0 && !src_q[i][0][9]) begin
                v[i] = 1'b1; l[i] = src_q[i][0][8]; d[i] = src_q[i][0][7:0];
            end
            data_in[8*i +: 8] = d[i];
        end
        valid_in = v;
        last_in  = l;
        #1;
        act_ack = ack_out;
        if (!reset_L) begin
        end else if (m_sync_left > 0) begin
            m_sync_left--;
        end else if (m_run == SYNC_PERIOD) begin
        end else if (m_open >= 0) begin
            if (v[m_open]) begin
                exp_ack[m_open] = 1'b1;
                m_stall = 0;
                if (l[m_open]) begin m_next = (m_open + 1) % N; m_open = -1; end
            end else begin
                m_stall++;
                if (m_stall == STALL_MAX) begin
                    abort = 1'b1; m_next = (m_open + 1) % N; m_open = -1; m_stall = 0;
                end
            end
        end else begin
            w = -1;
            for (int k = 0; k < N; k++) if (w < 0 && v[(m_next + k) % N]) w = (m_next + k) % N;
            if (w >= 0) begin
                exp_ack[w] = 1'b1;
                if (l[w]) m_next = (w + 1) % N; else begin m_open = w; m_stall = 0; end
            end
        end
        checks++;
        if (act_ack !== exp_ack) begin
            errors++;
            $display("FAIL ack cyc=%0d got=%b expected=%b", cyc, act_ack, exp_ack);
        end
        exp_valid = |exp_ack;
        exp_data  = COM;
        for (int i = 0; i < N; i++) if (exp_ack[i]) exp_data = d[i];
        exp_err = abort || m_bad;
        m_bad   = exp_valid && (exp_data == COM);
        m_run   = exp_valid ? m_run + 1 : 0;
        if (!reset_L) begin
            m_sync_left = SYNC_LEN; m_open = -1; m_next = 0; m_run = 0; m_stall = 0; m_bad = 1'b0;
            exp_err = 1'b0;
        end
        @(posedge clock4);
        #1;
        cyc++;
        for (int i = 0; i < N; i++)
            if (src_q[i].size() > 0 && (src_q[i][0][9] || act_ack[i])) void'(src_q[i].pop_front());
        checks++;
        if (data_out !== exp_data || valid_out !== exp_valid) begin
            errors++;
            $display("FAIL out cyc=%0d got data=%h valid=%b expected data=%h valid=%b",
                     cyc, data_out, valid_out, exp_data, exp_valid);
        end
        checks++;
        if (err_out !== exp_err) begin
            errors++;
            $display("FAIL err cyc=%0d got=%b expected=%b", cyc, err_out, exp_err);
        end
        log_ack.push_back(act_ack);
        log_data.push_back(data_out);
        log_valid.push_back(valid_out);
        log_err.push_back(err_out);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until_empty(input int budget);
        int n = 0;
        while (!all_empty() && n < budget) begin tick(); n++; end
        checks++;
        if (!all_empty()) begin
            errors++;
            $display("FAIL drain timeout after %0d cycles: pending=1 required pending=0", n);
        end
        run_ticks(3);
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) src_q[i].delete();
        reset_L = 1'b0;
        run_ticks(2);
        reset_L = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        do_reset();
        for (int r = 0; r < N; r++) begin
            push_byte(r, 8'(16 + r), 1'b0);
            push_byte(r, 8'(32 + r), 1'b1);
        end
        run_ticks(6);
        for (int k = 0; k < SYNC_LEN; k++) begin
            checks++;
            if (log_ack[k] !== '0 || log_valid[k] !== 1'b0 || log_data[k] !== COM) begin
                errors++;
                $display("FAIL reset_sync cycle %0d got ack=%b valid=%b data=%h required 0/0/bc",
                         k + 1, log_ack[k], log_valid[k], log_data[k]);
            end
        end
        checks++;
        if (log_ack[SYNC_LEN] !== N'(1) || log_data[SYNC_LEN] !== 8'h10) begin
            errors++;
            $display("FAIL first_grant got ack=%b data=%h required ack=0001 data=10",
                     log_ack[SYNC_LEN], log_data[SYNC_LEN]);
        end
    endtask

    task automatic test_two_packets();
        logic [7:0] s [$];
        logic [7:0] want [6] = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23};
        int last0, first1;
        do_reset();
        for (int b = 0; b < 3; b++) begin
            push_byte(0, 8'(8'h11 + b), b == 2);
            push_byte(2, 8'(8'h21 + b), b == 2);
        end
        run_until_empty(100);
        for (int k = 0; k < log_valid.size(); k++) if (log_valid[k]) s.push_back(log_data[k]);
        checks++;
        if (s.size() != 6 || s[0] !== want[0] || s[1] !== want[1] || s[2] !== want[2] ||
            s[3] !== want[3] || s[4] !== want[4] || s[5] !== want[5]) begin
            errors++;
            $display("FAIL two_packets got %0d bytes %p required %p", s.size(), s, want);
        end
        // Requester 1 rises while requester 0 owns the lane.
        do_reset();
        for (int b = 0; b < 3; b++) push_byte(0, 8'(8'h41 + b), b == 2);
        push_gaps(1, 5);
        push_byte(1, 8'h31, 1'b1);
        run_until_empty(100);
        last0 = -1; first1 = -1;
        for (int k = 0; k < log_ack.size(); k++) begin
            if (log_ack[k][0] && log_data[k] == 8'h43) last0 = k;
            if (log_ack[k][1] && first1 < 0) first1 = k;
        end
        checks++;
        if (last0 < 0 || first1 != last0 + 1) begin
            errors++;
            $display("FAIL no_interleave req1 first ack cycle %0d required %0d", first1, last0 + 1);
        end
    endtask

    task automatic test_stall_short();
        int i52, i53, nerr;
        do_reset();
        push_byte(0, 8'h51, 1'b0);
        push_byte(0, 8'h52, 1'b0);
        push_gaps(0, 3);
        push_byte(0, 8'h53, 1'b0);
        push_byte(0, 8'h54, 1'b1);
        run_until_empty(100);
        i52 = -1; i53 = -1; nerr = 0;
        for (int k = 0; k < log_valid.size(); k++) begin
            if (log_valid[k] && log_data[k] == 8'h52) i52 = k;
            if (log_valid[k] && log_data[k] == 8'h53) i53 = k;
            if (log_err[k]) nerr++;
        end
        checks++;
        if (i52 < 0 || i53 - i52 != 4) begin
            errors++;
            $display("FAIL stall_short bubbles got %0d required 3", i53 - i52 - 1);
        end
        checks++;
        if (nerr != 0) begin
            errors++;
            $display("FAIL stall_short err pulses got %0d required 0", nerr);
        end
    endtask

    task automatic test_stall_abort();
        int nerr, nxt;
        do_reset();
        push_byte(0, 8'h61, 1'b0);
        push_gaps(0, STALL_MAX);
        push_byte(0, 8'h62, 1'b1);
        push_gaps(1, 6);
        push_byte(1, 8'h71, 1'b1);
        push_byte(2, 8'h81, 1'b1);
        run_until_empty(100);
        nerr = 0; nxt = -1;
        for (int k = 0; k < log_err.size(); k++) if (log_err[k]) nerr++;
        for (int k = SYNC_LEN + 1; k < log_ack.size(); k++) if (nxt < 0 && log_ack[k] != '0) nxt = k;
        checks++;
        if (nerr != 1) begin
            errors++;
            $display("FAIL stall_abort err pulses got %0d required 1", nerr);
        end
        checks++;
        if (nxt < 0 || log_ack[nxt] !== N'(2)) begin
            errors++;
            $display("FAIL stall_abort next grant got %b required 0010", (nxt < 0) ? '0 : log_ack[nxt]);
        end
    endtask

    task automatic test_forced_sync();
        logic [7:0] s [$];
        int f, lastv, bad;
        do_reset();
        for (int b = 0; b < 40; b++) push_byte(1, 8'(b + 1), b == 39);
        run_until_empty(200);
        f = -1; lastv = -1; bad = 0;
        for (int k = 0; k < log_valid.size(); k++)
            if (log_valid[k]) begin
                if (f < 0) f = k;
                lastv = k;
                s.push_back(log_data[k]);
            end
        for (int b = 0; b < s.size(); b++) if (s[b] !== 8'(b + 1)) bad++;
        checks++;
        if (s.size() != 40 || bad != 0) begin
            errors++;
            $display("FAIL forced_sync stream got %0d bytes (%0d misordered) required 40 (0)", s.size(), bad);
        end
        checks++;
        if (f < 0 || log_valid[f+16] !== 1'b0 || log_valid[f+33] !== 1'b0 || lastv != f + 41) begin
            errors++;
            $display("FAIL forced_sync COM positions got span %0d required 41", lastv - f);
        end
    endtask

    task automatic test_bad_byte();
        do_reset();
        push_byte(3, COM, 1'b1);
        run_ticks(8);
        checks++;
        if (log_valid[SYNC_LEN] !== 1'b1 || log_data[SYNC_LEN] !== COM || log_err[SYNC_LEN] !== 1'b0) begin
            errors++;
            $display("FAIL bad_byte forward got valid=%b data=%h err=%b required 1/bc/0",
                     log_valid[SYNC_LEN], log_data[SYNC_LEN], log_err[SYNC_LEN]);
        end
        checks++;
        if (log_err[SYNC_LEN+1] !== 1'b1 || log_err[SYNC_LEN+2] !== 1'b0) begin
            errors++;
            $display("FAIL bad_byte err pulse got %b%b required 10",
                     log_err[SYNC_LEN+1], log_err[SYNC_LEN+2]);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        for (int b = 0; b < 5; b++) push_byte(0, 8'(8'h91 + b), b == 4);
        run_ticks(SYNC_LEN + 2);
        reset_L = 1'b0;
        #1;
        checks++;
        if (ack_out !== '0) begin
            errors++;
            $display("FAIL reset_mid ack during reset got %b required 0000", ack_out);
        end
        tick();
        reset_L = 1'b1;
        clear_logs();
        run_ticks(SYNC_LEN + 2);
        for (int k = 0; k < SYNC_LEN; k++) begin
            checks++;
            if (log_ack[k] !== '0 || log_valid[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid resync cycle %0d got ack=%b valid=%b required 0/0",
                         k + 1, log_ack[k], log_valid[k]);
            end
        end
        checks++;
        if (log_ack[SYNC_LEN] !== N'(1) || log_data[SYNC_LEN] !== 8'h93) begin
            errors++;
            $display("FAIL reset_mid regrant got ack=%b data=%h required 0001/93",
                     log_ack[SYNC_LEN], log_data[SYNC_LEN]);
        end
    endtask

    task automatic test_random();
        int total, sent, nerr, len;
        logic [7:0] d;
        do_reset();
        total = 0;
        for (int r = 0; r < N; r++) begin
            for (int p = 0; p < int'($urandom_range(2, 5)); p++) begin
                len = int'($urandom_range(1, 20));
                push_gaps(r, int'($urandom_range(0, 5)));
                for (int b = 0; b < len; b++) begin
                    if (b > 0 && $urandom_range(0, 3) == 0) push_gaps(r, int'($urandom_range(1, 3)));
                    d = 8'($urandom_range(0, 255));
                    if (d == COM) d = 8'hBD;
                    push_byte(r, d, b == len - 1);
                end
                total += len;
            end
        end
        run_until_empty(3000);
        sent = 0; nerr = 0;
        for (int k = 0; k < log_valid.size(); k++) begin
            if (log_valid[k]) sent++;
            if (log_err[k]) nerr++;
        end
        checks++;
        if (sent != total || nerr != 0) begin
            errors++;
            $display("FAIL random delivered=%0d err=%0d required %0d and 0", sent, nerr, total);
        end
    endtask

    initial begin
        reset_L  = 1'b0;
        valid_in = '0;
        last_in  = '0;
        data_in  = '0;
        m_sync_left = SYNC_LEN; m_open = -1; m_next = 0; m_run = 0; m_stall = 0; m_bad = 1'b0;
        @(posedge clock4);
        #1;
        test_reset();
        test_two_packets();
        test_stall_short();
        test_stall_abort();
        test_forced_sync();
        test_bad_byte();
        test_reset_mid_packet();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
